// File: rtl/serial_frame_tx_if.sv
// Producer handshake plus serial-line outputs of serial_frame_tx.
// The producer side takes master and the transmitter takes slave.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              sout;
    logic              sout_valid;
    logic              busy;
    logic              done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output sout,
        output sout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: accepts one payload word, then sends it MSB first
// as preamble, payload and even-parity bit, followed by an idle gap on a 1-bit line.
module serial_frame_tx #(
    parameter int               DATA_W     = 8,
    parameter int               PRE_W      = 4,
    parameter logic [PRE_W-1:0] PREAMBLE   = 4'b1011,
    parameter int               GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    serial_frame_tx_if.slave bus
);
    localparam int SH_W   = PRE_W + DATA_W + 1;
    localparam int MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAX_W  = (MAX_PD > GAP_CYCLES) ? MAX_PD : GAP_CYCLES;
    localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [SH_W-1:0]   sh;
    logic [SH_W-1:0]   sh_n;
    logic              sout_p1;
    logic              sout_n;
    logic              vld_p1;
    logic              vld_n;
    logic              done_p1;
    logic              done_n;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Frame is loaded whole into one shift register; its MSB is the next line bit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        sout_n  = 1'b0;
        vld_n   = 1'b0;
        done_n  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_n = S_PRE;
                    cnt_n   = '0;
                    sh_n    = {PREAMBLE, bus.in_data, even_parity(bus.in_data)};
                end
            end
            S_PRE: begin
                sh_n = {sh[SH_W-2:0], 1'b0};
                if (cnt == PRE_LAST) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                sh_n = {sh[SH_W-2:0], 1'b0};
                if (cnt == DATA_LAST) begin
                    state_n = S_PAR;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_PAR: begin
                sh_n    = {sh[SH_W-2:0], 1'b0};
                state_n = S_GAP;
                cnt_n   = '0;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Line outputs are derived from the next state so they register in step with it.
        vld_n  = (state_n == S_PRE) || (state_n == S_DATA) || (state_n == S_PAR);
        sout_n = vld_n & sh_n[SH_W-1];
        done_n = (state_n == S_GAP) && (cnt_n == GAP_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sh      <= '0;
            sout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sh      <= sh_n;
            sout_p1 <= sout_n;
            vld_p1  <= vld_n;
            done_p1 <= done_n;
        end
    end

    assign bus.in_ready   = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.sout       = sout_p1;
    assign bus.sout_valid = vld_p1;
    assign bus.done       = done_p1;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: queue-based frame model checked every cycle,
// plus literal frame patterns for fixed payloads.
module tb_serial_frame_tx;
    localparam int               DATA_W     = 8;
    localparam int               PRE_W      = 4;
    localparam logic [PRE_W-1:0] PREAMBLE   = 4'b1011;
    localparam int               GAP_CYCLES = 2;
    localparam int               FRAME_LEN  = PRE_W + DATA_W + 1 + GAP_CYCLES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_tx #(
        .DATA_W    (DATA_W),
        .PRE_W     (PRE_W),
        .PREAMBLE  (PREAMBLE),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: one queued entry per line cycle of each accepted frame.
    typedef struct packed {
        logic sout;
        logic vld;
        logic done;
    } beat_t;

    beat_t expq[$];
    beat_t cur;
    bit    cur_act;

    function automatic void push_frame(input logic [DATA_W-1:0] d);
        beat_t            b;
        logic [PRE_W-1:0] pre;
        pre = PREAMBLE;
        for (int i = PRE_W - 1; i >= 0; i--) begin
            b.sout = pre[i]; b.vld = 1'b1; b.done = 1'b0;
            expq.push_back(b);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            b.sout = d[i]; b.vld = 1'b1; b.done = 1'b0;
            expq.push_back(b);
        end
        b.sout = logic'($countones(d) % 2); b.vld = 1'b1; b.done = 1'b0;
        expq.push_back(b);
        for (int g = 0; g < GAP_CYCLES; g++) begin
            b.sout = 1'b0; b.vld = 1'b0; b.done = (g == GAP_CYCLES - 1);
            expq.push_back(b);
        end
    endfunction

    initial begin
        cur     = '0;
        cur_act = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                expq.delete();
                cur     = '0;
                cur_act = 1'b0;
            end else begin
                if (!cur_act && bus.in_valid === 1'b1) push_frame(bus.in_data);
                if (expq.size() != 0) begin
                    cur     = expq.pop_front();
                    cur_act = 1'b1;
                end else begin
                    cur     = '0;
                    cur_act = 1'b0;
                end
            end
            @(negedge clk);
            if (!rst) begin
                expq.delete();
                cur     = '0;
                cur_act = 1'b0;
            end
            chk("model_sout", bus.sout, cur.sout);
            chk("model_sout_valid", bus.sout_valid, cur.vld);
            chk("model_done", bus.done, cur.done);
            chk("model_busy", bus.busy, cur_act);
            if (rst) chk("model_in_ready", bus.in_ready, !cur_act);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            @(negedge clk);
            if (rst && bus.in_ready === 1'b1) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Sends one frame and compares its line bits against a literal pattern.
    task automatic run_frame(input logic [DATA_W-1:0] d, input logic [12:0] exp_bits,
                             input int pulse_k, input string nm);
        logic [12:0] got;
        int          vcnt;
        int          done_k;
        got    = '0;
        vcnt   = 0;
        done_k = -1;
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
        for (int k = 1; k <= FRAME_LEN + 1; k++) begin
            @(negedge clk);
            if (k <= 13) got = {got[11:0], bus.sout};
            if (bus.sout_valid === 1'b1) vcnt++;
            if (bus.done === 1'b1) done_k = k;
            if (k == FRAME_LEN + 1) chk({nm, "_in_ready_after"}, bus.in_ready, 1'b1);
            if (k == pulse_k) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h55;
            end
            if (k == pulse_k + 1) bus.in_valid = 1'b0;
        end
        chk({nm, "_bits"}, got, exp_bits);
        chk({nm, "_vld_cycles"}, vcnt, 13);
        chk({nm, "_done_cycle"}, done_k, 15);
    endtask

    logic sb [1:32];
    logic vb [1:32];

    initial begin
        logic [12:0] g1;
        logic [12:0] g2;
        int          zeros;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);

        run_frame(8'hA5, 13'b1011_1010_0101_0, 0, "a5");
        run_frame(8'h01, 13'b1011_0000_0001_1, 0, "p01");
        run_frame(8'hFF, 13'b1011_1111_1111_0, 0, "pff");
        run_frame(8'h00, 13'b1011_0000_0000_0, 0, "p00");

        // Back-to-back with in_valid held high.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        @(posedge clk);
        #1 bus.in_data = 8'hC3;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            sb[k] = bus.sout;
            vb[k] = bus.sout_valid;
            if (k == 17) bus.in_valid = 1'b0;
        end
        g1 = '0;
        g2 = '0;
        for (int i = 0; i < 13; i++) begin
            g1 = {g1[11:0], sb[1 + i]};
            g2 = {g2[11:0], sb[17 + i]};
        end
        zeros = 0;
        for (int k = 14; k <= 16; k++) if (vb[k] == 1'b0) zeros++;
        chk("b2b_first_bits", g1, 13'b1011_0011_1100_0);
        chk("b2b_second_bits", g2, 13'b1011_1100_0011_0);
        chk("b2b_gap_cycles", zeros, 3);
        chk("b2b_second_start", vb[17], 1'b1);

        // Valid pulse during DATA is ignored.
        run_frame(8'hA5, 13'b1011_1010_0101_0, 7, "busy_pulse");
        repeat (5) begin
            @(negedge clk);
            chk("busy_pulse_no_2nd", bus.sout_valid, 1'b0);
        end

        // Reset during the third data bit.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_sout", bus.sout, 1'b0);
        chk("midrst_vld", bus.sout_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        run_frame(8'h81, 13'b1011_1000_0001_0, 0, "p81");

        // Random traffic with one reset pulse.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = ($urandom_range(0, 2) == 0);
            bus.in_data  = DATA_W'($urandom);
            if (c == 300) rst = 1'b0;
            if (c == 303) rst = 1'b1;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (FRAME_LEN + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
